// File: rtl/bsg_manycore_loader_pkg.sv
// Shared types and constants for the rectangular SPMD loader: FSM states,
// packet opcodes and the width helpers used to size coordinates and packets.
package bsg_manycore_loader_pkg;

    typedef enum logic [2:0] {
        LOADER_IDLE,
        LOADER_LOAD,
        LOADER_UNFREEZE,
        LOADER_DRAIN,
        LOADER_DONE
    } loader_state_e;

    localparam logic [1:0] OP_STORE       = 2'b01;
    localparam logic [3:0] OP_EX_STORE    = 4'b1111;
    localparam logic [1:0] OP_UNFREEZE    = 2'b10;
    localparam logic [3:0] OP_EX_UNFREEZE = 4'b0000;

    // Never returns zero, so a one-entry dimension still gets a one-bit field.
    function automatic int safe_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Packet layout, MSB to LSB: {addr, op, op_ex, data, y_cord, x_cord}.
    function automatic int orig_packet_width(input int addr_w, input int data_w,
                                             input int x_w, input int y_w);
        return addr_w + 2 + 4 + data_w + y_w + x_w;
    endfunction

endpackage

// File: rtl/bsg_manycore_spmd_loader_rect_if.sv
// Link and memory signals of the loader: packet output with valid/ready and
// credit return, plus the zero-latency program memory port.
interface bsg_manycore_spmd_loader_rect_if #(
    parameter int packet_width_p   = 58,
    parameter int mem_data_width_p = 32,
    parameter int mem_addr_width_p = 16
);

    logic [packet_width_p-1:0]   data_o;
    logic                        v_o;
    logic                        ready_i;
    logic                        credit_i;
    logic [mem_data_width_p-1:0] data_i;
    logic [mem_addr_width_p-1:0] addr_o;

    modport master (
        output data_o,
        output v_o,
        output addr_o,
        input  ready_i,
        input  credit_i,
        input  data_i
    );

    modport slave (
        input  data_o,
        input  v_o,
        input  addr_o,
        output ready_i,
        output credit_i,
        output data_i
    );

endinterface

// File: rtl/bsg_manycore_loader_credits.sv
// Up/down counter of link credits, starting full; a credit returned while the
// counter is already full sets a sticky error instead of overflowing.
module bsg_manycore_loader_credits #(
    parameter int max_out_credits_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic fire_i,
    input  logic credit_i,
    input  logic clear_err_i,
    output logic avail_o,
    output logic full_o,
    output logic err_o
);

    localparam int width_lp = $clog2(max_out_credits_p + 1);
    localparam logic [width_lp-1:0] max_lp = width_lp'(max_out_credits_p);

    logic [width_lp-1:0] credits_q, credits_d;
    logic                err_q, err_d;

    // A fire and a returning credit in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q & ~clear_err_i;
        if (credit_i && !fire_i) begin
            if (credits_q == max_lp) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end else if (fire_i && !credit_i) begin
            credits_d = credits_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q <= max_lp;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign avail_o = (credits_q != '0);
    assign full_o  = (credits_q == max_lp);
    assign err_o   = err_q;

endmodule

// File: rtl/bsg_manycore_spmd_loader_rect.sv
// Streams a program image into a rectangle of tiles, patching each tile's ID
// word, then unfreezes every tile. Optional BSG_SPMD_LOADER_SKIP_ZERO_EN skips zero words.
module bsg_manycore_spmd_loader_rect
    import bsg_manycore_loader_pkg::*;
#(
    parameter int mem_size_p        = 16,
    parameter int data_width_p      = 32,
    parameter int hdata_width_p     = data_width_p,
    parameter int addr_width_p      = 16,
    parameter int haddr_width_p     = addr_width_p,
    parameter int tile_id_ptr_p     = 8,
    parameter int num_rows_p        = 4,
    parameter int num_cols_p        = 4,
    parameter int load_rows_p       = num_rows_p,
    parameter int load_cols_p       = num_cols_p,
    parameter int origin_x_p        = 0,
    parameter int origin_y_p        = 0,
    parameter int max_out_credits_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    bsg_manycore_spmd_loader_rect_if.master link
);

    localparam int x_cord_width_lp = safe_clog2(num_cols_p);
    localparam int y_cord_width_lp = safe_clog2(num_rows_p + 1);
    localparam int packet_width_lp = orig_packet_width(addr_width_p, data_width_p,
                                                       x_cord_width_lp, y_cord_width_lp);
    localparam int bytes_lp        = data_width_p / 8;
    localparam int byte_shift_lp   = $clog2(bytes_lp);

    localparam logic [addr_width_p-1:0]    word_step_lp   = addr_width_p'(bytes_lp);
    localparam logic [addr_width_p-1:0]    last_byte_lp   = addr_width_p'(mem_size_p - bytes_lp);
    localparam logic [addr_width_p-1:0]    tile_id_ptr_lp = addr_width_p'(tile_id_ptr_p);
    localparam logic [x_cord_width_lp-1:0] last_col_lp    = x_cord_width_lp'(load_cols_p - 1);
    localparam logic [y_cord_width_lp-1:0] last_row_lp    = y_cord_width_lp'(load_rows_p - 1);
    localparam logic [x_cord_width_lp-1:0] origin_x_lp    = x_cord_width_lp'(origin_x_p);
    localparam logic [y_cord_width_lp-1:0] origin_y_lp    = y_cord_width_lp'(origin_y_p);
    localparam logic [data_width_p-1:0]    load_cols_lp   = data_width_p'(load_cols_p);

    loader_state_e               state_q, state_d;
    logic [addr_width_p-1:0]     byte_addr_q, byte_addr_d;
    logic [y_cord_width_lp-1:0]  row_q, row_d;
    logic [x_cord_width_lp-1:0]  col_q, col_d;

    logic                        credits_avail;
    logic                        credits_full;
    logic                        clear_err;
    logic                        send_state;
    logic                        is_id_word;
    logic                        skip_word;
    logic                        valid;
    logic                        fire;
    logic                        last_col;
    logic                        last_tile;
    logic [y_cord_width_lp-1:0]  row_adv;
    logic [x_cord_width_lp-1:0]  col_adv;
    logic [data_width_p-1:0]     mem_word;
    logic [data_width_p-1:0]     tile_id;
    logic [1:0]                  pkt_op;
    logic [3:0]                  pkt_op_ex;
    logic [addr_width_p-1:0]     pkt_addr;
    logic [data_width_p-1:0]     pkt_data;
    logic [packet_width_lp-1:0]  packet;

    assign mem_word   = data_width_p'(link.data_i);
    assign send_state = (state_q == LOADER_LOAD) || (state_q == LOADER_UNFREEZE);
    assign is_id_word = (byte_addr_q == tile_id_ptr_lp);
    assign tile_id    = (data_width_p'(row_q) * load_cols_lp) + data_width_p'(col_q);

`ifdef BSG_SPMD_LOADER_SKIP_ZERO_EN
    // Zero words need no store; the ID word always goes out since it gets patched.
    assign skip_word = (state_q == LOADER_LOAD) && !is_id_word && (mem_word == '0);
`else
    assign skip_word = 1'b0;
`endif

    assign valid = send_state && credits_avail && !skip_word;
    assign fire  = valid && link.ready_i;

    assign last_col  = (col_q == last_col_lp);
    assign last_tile = last_col && (row_q == last_row_lp);
    assign col_adv   = last_col ? '0 : col_q + 1'b1;
    assign row_adv   = last_tile ? '0 : (last_col ? row_q + 1'b1 : row_q);

    bsg_manycore_loader_credits #(
        .max_out_credits_p (max_out_credits_p)
    ) credits (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .fire_i      (fire),
        .credit_i    (link.credit_i),
        .clear_err_i (clear_err),
        .avail_o     (credits_avail),
        .full_o      (credits_full),
        .err_o       (err_o)
    );

    // Tiles are walked row-major; a store cursor reaching the last word of the
    // last tile hands over to the unfreeze pass with all cursors back at zero.
    always_comb begin
        state_d     = state_q;
        byte_addr_d = byte_addr_q;
        row_d       = row_q;
        col_d       = col_q;
        clear_err   = 1'b0;
        case (state_q)
            LOADER_IDLE, LOADER_DONE: begin
                if (start_i) begin
                    state_d     = LOADER_LOAD;
                    byte_addr_d = '0;
                    row_d       = '0;
                    col_d       = '0;
                    clear_err   = 1'b1;
                end
            end
            LOADER_LOAD: begin
                if (fire || skip_word) begin
                    if (byte_addr_q == last_byte_lp) begin
                        byte_addr_d = '0;
                        col_d       = col_adv;
                        row_d       = row_adv;
                        if (last_tile) begin
                            state_d = LOADER_UNFREEZE;
                        end
                    end else begin
                        byte_addr_d = byte_addr_q + word_step_lp;
                    end
                end
            end
            LOADER_UNFREEZE: begin
                if (fire) begin
                    col_d = col_adv;
                    row_d = row_adv;
                    if (last_tile) begin
                        state_d = LOADER_DRAIN;
                    end
                end
            end
            LOADER_DRAIN: begin
                if (credits_full) begin
                    state_d = LOADER_DONE;
                end
            end
            default: begin
                state_d = LOADER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= LOADER_IDLE;
            byte_addr_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            byte_addr_q <= byte_addr_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    always_comb begin
        pkt_op    = OP_UNFREEZE;
        pkt_op_ex = OP_EX_UNFREEZE;
        pkt_addr  = '0;
        pkt_data  = '0;
        if (state_q == LOADER_LOAD) begin
            pkt_op    = OP_STORE;
            pkt_op_ex = OP_EX_STORE;
            pkt_addr  = byte_addr_q;
            pkt_data  = is_id_word ? tile_id : mem_word;
        end
    end

    assign packet = {pkt_addr, pkt_op, pkt_op_ex, pkt_data,
                     origin_y_lp + row_q, origin_x_lp + col_q};

    assign link.v_o    = valid;
    assign link.data_o = valid ? packet : '0;
    assign link.addr_o = haddr_width_p'(byte_addr_q >> byte_shift_lp);

    assign busy_o = send_state || (state_q == LOADER_DRAIN);
    assign done_o = (state_q == LOADER_DONE);

endmodule

// File: tb/tb_bsg_manycore_spmd_loader_rect.sv
// Directed bench for the rectangular SPMD loader: 2x2 rectangle at origin (1,0),
// 16-byte image, two credits; a scoreboard checks every fired packet in order.
module tb_bsg_manycore_spmd_loader_rect;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int XW  = 2;
    localparam int YW  = 2;
    localparam int PW  = AW + 2 + 4 + DW + YW + XW;
    localparam int OP_LSB = DW + YW + XW + 4;
    localparam int LR  = 2;
    localparam int LC  = 2;
    localparam int OX  = 1;
    localparam int OY  = 0;
    localparam int PTR = 8;
    localparam int MEM = 16;

    logic clk;
    logic reset_n;
    logic start;
    logic busy;
    logic done;
    logic err;

    logic readyLevel;
    logic toggleEn;
    logic toggleBit;
    logic autoCredit;
    logic autoPulse;
    logic manualCredit;
    logic fireSeen;
    logic stallPending;
    logic [AW-1:0] stallAddr;

    int vectors;
    int miscompares;
    int fireCount;
    int storeCount;
    int expStores;
    logic [PW-1:0] expQ[$];

    bsg_manycore_spmd_loader_rect_if #(
        .packet_width_p   (PW),
        .mem_data_width_p (DW),
        .mem_addr_width_p (AW)
    ) link ();

    bsg_manycore_spmd_loader_rect #(
        .mem_size_p        (MEM),
        .data_width_p      (DW),
        .addr_width_p      (AW),
        .tile_id_ptr_p     (PTR),
        .num_rows_p        (2),
        .num_cols_p        (4),
        .load_rows_p       (LR),
        .load_cols_p       (LC),
        .origin_x_p        (OX),
        .origin_y_p        (OY),
        .max_out_credits_p (2)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .link      (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: words 1 and 2 are zero, word 2 is also the tile-ID word.
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] idx);
        case (idx)
            16'd0:   return 32'hCAFE_0001;
            16'd1:   return 32'h0000_0000;
            16'd2:   return 32'h0000_0000;
            16'd3:   return 32'h0BAD_F00D;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [PW-1:0] makePacket(input int addr, input logic [1:0] op,
                                                 input logic [3:0] opEx, input logic [DW-1:0] data,
                                                 input int y, input int x);
        return {AW'(addr), op, opEx, data, YW'(y), XW'(x)};
    endfunction

    always_comb link.data_i = memWord(link.addr_o);
    assign link.ready_i  = toggleEn ? toggleBit : readyLevel;
    assign link.credit_i = autoPulse | manualCredit;

    always @(posedge clk) begin
        #1;
        toggleBit = ~toggleBit;
        autoPulse = autoCredit && fireSeen;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every fire is compared against the next expected packet,
    // and an address presented under back-pressure must still be there next time.
    always @(negedge clk) begin
        fireSeen = link.v_o && link.ready_i;
        if (!reset_n) begin
            stallPending = 1'b0;
        end else begin
            if (stallPending && link.v_o) checkOutput("addr_hold", link.addr_o, stallAddr);
            stallPending = link.v_o && !link.ready_i;
            stallAddr    = link.addr_o;
        end
        if (fireSeen) begin
            fireCount++;
            if (link.data_o[OP_LSB +: 2] == 2'b01) storeCount++;
            if (expQ.size() == 0) begin
                checkOutput("extra_fire", link.v_o, 0);
            end else begin
                checkOutput("packet", link.data_o, expQ.pop_front());
            end
        end
    end

    task automatic buildExpected();
        logic send;
        expQ.delete();
        expStores  = 0;
        fireCount  = 0;
        storeCount = 0;
        for (int r = 0; r < LR; r++) begin
            for (int c = 0; c < LC; c++) begin
                for (int w = 0; w < MEM / 4; w++) begin
                    send = 1'b1;
`ifdef BSG_SPMD_LOADER_SKIP_ZERO_EN
                    if ((w * 4 != PTR) && (memWord(AW'(w)) == '0)) send = 1'b0;
`endif
                    if (send) begin
                        expQ.push_back(makePacket(w * 4, 2'b01, 4'hF,
                                                  (w * 4 == PTR) ? DW'(r * LC + c) : memWord(AW'(w)),
                                                  r + OY, c + OX));
                        expStores++;
                    end
                end
            end
        end
        for (int r = 0; r < LR; r++) begin
            for (int c = 0; c < LC; c++) begin
                expQ.push_back(makePacket(0, 2'b10, 4'h0, '0, r + OY, c + OX));
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!done) checkOutput("done_timeout", done, 1);
    endtask

    task automatic checkRunEnd();
        checkOutput("queue_left", expQ.size(), 0);
        checkOutput("store_count", storeCount, expStores);
        checkOutput("busy_at_done", busy, 0);
    endtask

    task automatic pulseCredit();
        @(posedge clk);
        #1 manualCredit = 1'b1;
        @(posedge clk);
        #1 manualCredit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] watchdog expired before the run completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        vectors      = 0;
        miscompares  = 0;
        fireCount    = 0;
        storeCount   = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        readyLevel   = 1'b0;
        toggleEn     = 1'b0;
        toggleBit    = 1'b0;
        autoCredit   = 1'b0;
        autoPulse    = 1'b0;
        manualCredit = 1'b0;
        fireSeen     = 1'b0;
        stallPending = 1'b0;
        stallAddr    = '0;

        #3;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_v", link.v_o, 0);
        checkOutput("rst_addr", link.addr_o, 0);
        checkOutput("rst_data", link.data_o, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] basic load");
        readyLevel = 1'b1;
        autoCredit = 1'b1;
        buildExpected();
        applyStimulus();
        checkOutput("first_v", link.v_o, 1);
        checkOutput("first_addr", link.addr_o, 0);
        checkOutput("first_busy", busy, 1);
        checkOutput("first_done", done, 0);
        waitDone(500);
        checkRunEnd();

        $display("[TB] credit overflow in DONE");
        pulseCredit();
        #1;
        checkOutput("ovf_err", err, 1);
        checkOutput("ovf_done", done, 1);

        $display("[TB] restart with back-pressure");
        toggleEn = 1'b1;
        buildExpected();
        applyStimulus();
        checkOutput("restart_err", err, 0);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_busy", busy, 1);
        waitDone(1000);
        checkRunEnd();
        toggleEn = 1'b0;

        $display("[TB] credit stall");
        autoCredit = 1'b0;
        buildExpected();
        applyStimulus();
        repeat (10) @(posedge clk);
        #2;
        checkOutput("stall_fires", fireCount, 2);
        checkOutput("stall_v", link.v_o, 0);
        pulseCredit();
        repeat (6) @(posedge clk);
        #2;
        checkOutput("release_fires", fireCount, 3);
        checkOutput("release_v", link.v_o, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("stall_rst_busy", busy, 0);
        expQ.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] async reset mid-load");
        autoCredit = 1'b1;
        buildExpected();
        applyStimulus();
        n = 0;
        while (storeCount < 7 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("store7_reached", storeCount, 7);
        checkOutput("pre_rst_v", link.v_o, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_v", link.v_o, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_addr", link.addr_o, 0);
        checkOutput("async_data", link.data_o, 0);
        expQ.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] load after reset");
        buildExpected();
        applyStimulus();
        checkOutput("again_addr", link.addr_o, 0);
        checkOutput("again_pkt", link.data_o, makePacket(0, 2'b01, 4'hF, memWord(0), OY, OX));
        waitDone(500);
        checkRunEnd();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
